// File: rtl/key_evt_counter.sv
// Two debounced, auto-repeating push-button channels driving a modulo up/down counter.
// o_cnt goes straight to the 7-segment decoder; o_evt carries one-cycle press/repeat events.
module key_evt_counter #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [1:0]       i_key_n,
    output logic [1:0]       o_evt,
    output logic [1:0]       o_held,
    output logic [CNT_W-1:0] o_cnt
);

    localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int T_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RT_W   = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

    localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEB_CYCLES - 1);
    localparam logic [RT_W-1:0]   DLY_LAST = (REPEAT_DELAY > 0) ? RT_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [RT_W-1:0]   PER_LAST = RT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_key
            logic              sync1_q, sync2_q;
            logic              k_s;
            logic [DCNT_W-1:0] dcnt_q, dcnt_d;
            logic              held_q, held_d;
            logic              held_prev_q;
            state_e            state_q, state_d;
            logic [RT_W-1:0]   rt_q, rt_d;
            logic              evt_q, evt_d;

            // Synchroniser resets to "released" so a key held through reset is seen as a new press.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= i_key_n[g];
                    sync2_q <= sync1_q;
                end
            end

            assign k_s = ~sync2_q;

            always_comb begin
                dcnt_d = '0;
                held_d = held_q;
                if (k_s != held_q) begin
                    if (dcnt_q == DEB_LAST) begin
                        held_d = k_s;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end

            // Release always wins over a timer expiring in the same cycle.
            always_comb begin
                state_d = state_q;
                rt_d    = rt_q;
                evt_d   = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (held_q && !held_prev_q) begin
                            evt_d = 1'b1;
                            rt_d  = '0;
                            if (REPEAT_DELAY > 0) begin
                                state_d = ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (!held_q) begin
                            state_d = ST_IDLE;
                            rt_d    = '0;
                        end else if (rt_q == DLY_LAST) begin
                            evt_d   = 1'b1;
                            rt_d    = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            rt_d = rt_q + RT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!held_q) begin
                            state_d = ST_IDLE;
                            rt_d    = '0;
                        end else if (rt_q == PER_LAST) begin
                            evt_d = 1'b1;
                            rt_d  = '0;
                        end else begin
                            rt_d = rt_q + RT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rt_d    = '0;
                    end
                endcase
            end

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    dcnt_q      <= '0;
                    held_q      <= 1'b0;
                    held_prev_q <= 1'b0;
                    state_q     <= ST_IDLE;
                    rt_q        <= '0;
                    evt_q       <= 1'b0;
                end else begin
                    dcnt_q      <= dcnt_d;
                    held_q      <= held_d;
                    held_prev_q <= held_q;
                    state_q     <= state_d;
                    rt_q        <= rt_d;
                    evt_q       <= evt_d;
                end
            end

            assign o_evt[g]  = evt_q;
            assign o_held[g] = held_q;
        end
    endgenerate

    // Simultaneous UP and DOWN events cancel.
    always_comb begin
        cnt_d = cnt_q;
        case (o_evt)
            2'b01:   cnt_d = cnt_q + CNT_W'(1);
            2'b10:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: tb/tb_key_evt_counter.sv
// Scoreboard bench for key_evt_counter: directed scenarios plus random key activity,
// checked against an event-schedule model of the debounce/repeat rules.
module tb_key_evt_counter;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int CW  = 4;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [1:0]    i_key_n;
    logic [1:0]    o_evt;
    logic [1:0]    o_held;
    logic [CW-1:0] o_cnt;

    key_evt_counter #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .CNT_W        (CW)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .i_key_n  (i_key_n),
        .o_evt    (o_evt),
        .o_held   (o_held),
        .o_cnt    (o_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0]    evt;
        logic [1:0]    held;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   evt_seen0 = 0;
    int   evt_seen1 = 0;

    // Reference model state
    int            n_edge = 0;
    bit [1:0]      rawprev = 2'b11;
    bit [DEB-1:0]  kwin [2];
    int            kval [2];
    bit [1:0]      held_m = 2'b00;
    bit [1:0]      evt_m  = 2'b00;
    bit [CW-1:0]   cnt_m  = '0;
    int            press_t [2];
    bit            press_v [2];

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit [1:0] key, input bit rn);
        exp_t     e;
        bit [1:0] ne;
        bit       old;
        int       d;
        n_edge++;
        if (!rn) begin
            rawprev = 2'b11;
            held_m  = 2'b00;
            evt_m   = 2'b00;
            cnt_m   = '0;
            for (int i = 0; i < 2; i++) begin
                kwin[i]    = '0;
                kval[i]    = 0;
                press_v[i] = 1'b0;
            end
        end else begin
            cnt_m = cnt_m + CW'(evt_m[0]) - CW'(evt_m[1]);
            ne = 2'b00;
            for (int i = 0; i < 2; i++) begin
                old = held_m[i];
                if (old && press_v[i]) begin
                    d = n_edge - press_t[i] - 1;
                    if (d == 0 || (d >= RD && ((d - RD) % RP) == 0)) ne[i] = 1'b1;
                end
                if (kval[i] >= DEB && kwin[i] == {DEB{~old}}) held_m[i] = ~old;
                kwin[i] = {kwin[i][DEB-2:0], ~rawprev[i]};
                if (kval[i] < DEB) kval[i]++;
                rawprev[i] = key[i];
                if (!old && held_m[i]) begin
                    press_t[i] = n_edge;
                    press_v[i] = 1'b1;
                end
                if (old && !held_m[i]) press_v[i] = 1'b0;
            end
            evt_m = ne;
        end
        e.evt  = evt_m;
        e.held = held_m;
        e.cnt  = cnt_m;
        expq.push_back(e);
    endtask

    task automatic step(input bit [1:0] key, input bit rn);
        @(negedge sys_clk);
        #1;
        i_key_n   = key;
        sys_rst_n = rn;
        @(posedge sys_clk);
        model_edge(key, rn);
    endtask

    task automatic hold(input bit [1:0] key, input int cycles);
        for (int c = 0; c < cycles; c++) step(key, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) step(2'b11, 1'b0);
    endtask

    task automatic settle;
        @(negedge sys_clk);
        #1;
    endtask

    // Monitor: every cycle presents an output word; pop and compare.
    always @(negedge sys_clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            cmp("evt",  int'(o_evt),  int'(e.evt));
            cmp("held", int'(o_held), int'(e.held));
            cmp("cnt",  int'(o_cnt),  int'(e.cnt));
        end
        if (o_evt[0]) evt_seen0++;
        if (o_evt[1]) evt_seen1++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit [1:0] lvl;
        int       run [2];
        bit       rn;
        sys_rst_n = 1'b0;
        i_key_n   = 2'b11;
        do_reset(3);
        settle();
        cmp("reset_cnt",  int'(o_cnt),  0);
        cmp("reset_held", int'(o_held), 0);

        // Single short press
        evt_seen0 = 0;
        hold(2'b10, 10);
        hold(2'b11, 20);
        settle();
        cmp("t1_cnt", int'(o_cnt), 1);
        cmp("t1_evts", evt_seen0, 1);

        // Bounce shorter than the debounce window
        do_reset(2);
        evt_seen0 = 0;
        for (int c = 0; c < 10; c++) begin
            hold(2'b10, 3);
            hold(2'b11, 3);
        end
        settle();
        cmp("t2_cnt", int'(o_cnt), 0);
        cmp("t2_evts", evt_seen0, 0);

        // Long hold with auto-repeat
        do_reset(2);
        evt_seen0 = 0;
        hold(2'b10, 60);
        hold(2'b11, 20);
        settle();
        cmp("t3_cnt", int'(o_cnt), 6);
        cmp("t3_evts", evt_seen0, 6);

        // Wrap down and back up
        do_reset(2);
        hold(2'b01, 10);
        hold(2'b11, 15);
        settle();
        cmp("t4_down_wrap", int'(o_cnt), 15);
        hold(2'b10, 10);
        hold(2'b11, 15);
        settle();
        cmp("t4_up_wrap", int'(o_cnt), 0);

        // Both keys together
        evt_seen0 = 0;
        evt_seen1 = 0;
        hold(2'b00, 10);
        hold(2'b11, 15);
        settle();
        cmp("t5_cnt", int'(o_cnt), 0);
        cmp("t5_up_evts", evt_seen0, 1);
        cmp("t5_dn_evts", evt_seen1, 1);

        // Reset during repeat while key stays pressed
        hold(2'b10, 40);
        for (int c = 0; c < 5; c++) step(2'b10, 1'b0);
        settle();
        cmp("t6_rst_cnt", int'(o_cnt), 0);
        cmp("t6_rst_evt", int'(o_evt), 0);
        evt_seen0 = 0;
        hold(2'b10, 20);
        hold(2'b11, 15);
        settle();
        cmp("t6_cnt", int'(o_cnt), 1);
        cmp("t6_evts", evt_seen0, 1);

        // Random key activity with occasional resets
        run[0] = 0;
        run[1] = 0;
        lvl    = 2'b11;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (run[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    run[i] = $urandom_range(1, 30);
                end
                run[i]--;
            end
            rn = ($urandom_range(0, 399) != 0);
            step(lvl, rn);
        end
        hold(2'b11, 10);
        settle();
        settle();
        cmp("drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
